// File: rtl/pwm_line_feeder.sv
// pwm_line_feeder: buffers an upstream byte stream and replays it to the
// 8-channel PWM stage one full line at a time. A line is a start pulse with
// byte 0 followed by the remaining bytes on back-to-back cycles. After each
// line there is a programmable quiet gap so the PWM can finish its window.
module pwm_line_feeder #(
   parameter int STAGE  = 8,
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 16,
   parameter int GAP    = 8
) (
   input  logic                     clkfordata,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DWIDTH-1:0]        in_data,
   output logic                     in_ready,
   output logic                     start,
   output logic [DWIDTH-1:0]        data,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     drop,
   output logic [15:0]              lines
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int KW = $clog2(STAGE) + 1;
   localparam int GW = $clog2(GAP) + 1;

   localparam logic [LW-1:0] STAGE_LVL = LW'(STAGE);
   localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
   localparam logic [KW-1:0] STAGE_K   = KW'(STAGE);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [KW-1:0]     byte_idx;
   logic [GW-1:0]     gap_cnt;

   logic              push;
   logic              pop;
   logic              launch;
   logic              line_done;
   logic [DWIDTH-1:0] data_next;

   assign in_ready = (level < DEPTH_LVL);
   assign push     = in_valid && in_ready;

   // State register; busy is registered from the same next-state decision.
   always_ff @(posedge clkfordata) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
      end
   end

   // Next-state: a line starts only when a whole line is buffered, and the
   // last gap cycle may chain straight into the next line.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (level >= STAGE_LVL) begin
               next_state = SEND;
            end
         end
         SEND: begin
            if (byte_idx == STAGE_K) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            if (gap_cnt == '0) begin
               if (level >= STAGE_LVL) begin
                  next_state = SEND;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode: which edges launch a line, pop a byte, or close a line.
   always_comb begin
      launch    = (state != SEND) && (next_state == SEND);
      line_done = (state == SEND) && (next_state == HOLD);
      pop       = launch || ((state == SEND) && (byte_idx != STAGE_K));
      data_next = pop ? mem[rd_ptr] : '0;
   end

   // Registered PWM load interface plus the per-line byte index, gap timer
   // and line counter.
   always_ff @(posedge clkfordata) begin
      if (rst) begin
         start    <= 1'b0;
         data     <= '0;
         byte_idx <= '0;
         gap_cnt  <= '0;
         lines    <= '0;
      end else begin
         start <= launch;
         data  <= data_next;
         if (launch) begin
            byte_idx <= KW'(1);
         end else if (pop) begin
            byte_idx <= byte_idx + KW'(1);
         end
         if (line_done) begin
            gap_cnt <= GAP_LOAD;
            lines   <= lines + 16'd1;
         end else if ((state == HOLD) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
      end
   end

   // FIFO bookkeeping: pointers wrap naturally, occupancy tracks push/pop,
   // and any byte offered while full is discarded and flagged for good.
   always_ff @(posedge clkfordata) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         drop   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (in_valid && !in_ready) begin
            drop <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clkfordata) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

endmodule

// File: tb/tb_pwm_line_feeder.sv
// tb_pwm_line_feeder: drives pwm_line_feeder with directed and random byte
// streams and compares every output after every edge with a queue-based
// model of the line feeder.
module tb_pwm_line_feeder;

   localparam int STAGE  = 8;
   localparam int DWIDTH = 8;
   localparam int DEPTH  = 16;
   localparam int GAP    = 8;

   logic              clkfordata = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [DWIDTH-1:0] in_data;
   logic              in_ready;
   logic              start;
   logic [DWIDTH-1:0] data;
   logic              busy;
   logic [4:0]        level;
   logic              drop;
   logic [15:0]       lines;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Model state: accepted-but-unlaunched bytes, bytes of the line in
   // flight, and the cycle number of the most recent start.
   logic [7:0] fifo_q [$];
   logic [7:0] pend   [$];
   int         cyc = 0;
   int         last_start = 0;
   bit         started_any = 0;

   logic        exp_start;
   logic [7:0]  exp_data;
   logic        exp_busy;
   logic [4:0]  exp_level;
   logic        exp_drop;
   logic [15:0] exp_lines;
   logic        exp_ready;

   logic [7:0] pat [8] = '{8'h01, 8'h20, 8'h40, 8'h7F, 8'h80, 8'hC0, 8'hFE, 8'hFF};

   pwm_line_feeder #(
      .STAGE  (STAGE),
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .GAP    (GAP)
   ) dut (
      .clkfordata (clkfordata),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .start      (start),
      .data       (data),
      .busy       (busy),
      .level      (level),
      .drop       (drop),
      .lines      (lines)
   );

   always #5 clkfordata = ~clkfordata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
      int occ;
      cyc++;
      if (r) begin
         fifo_q.delete();
         pend.delete();
         started_any = 0;
         exp_start = 1'b0;
         exp_data  = 8'h00;
         exp_busy  = 1'b0;
         exp_level = 5'd0;
         exp_drop  = 1'b0;
         exp_lines = 16'd0;
         exp_ready = 1'b1;
         return;
      end
      occ = fifo_q.size() + pend.size();
      if (v && occ >= DEPTH) exp_drop = 1'b1;
      exp_start = 1'b0;
      exp_data  = 8'h00;
      if (pend.size() == 0 && fifo_q.size() >= STAGE &&
          (!started_any || (cyc - last_start) >= STAGE + GAP)) begin
         for (int i = 0; i < STAGE; i++) pend.push_back(fifo_q.pop_front());
         last_start  = cyc;
         started_any = 1;
         exp_start   = 1'b1;
      end
      if (pend.size() > 0) exp_data = pend.pop_front();
      if (started_any && (cyc - last_start) == STAGE) exp_lines = exp_lines + 16'd1;
      exp_busy = started_any && ((cyc - last_start) < STAGE + GAP);
      if (v && occ < DEPTH) fifo_q.push_back(d);
      exp_level = 5'(fifo_q.size() + pend.size());
      exp_ready = (exp_level < 5'(DEPTH));
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      @(negedge clkfordata);
      in_valid = v;
      in_data  = d;
      rst      = r;
      model_edge(v, d, r);
      @(posedge clkfordata);
      #1;
   endtask

   task automatic checkOutput();
      check("start",    32'(start),    32'(exp_start));
      check("data",     32'(data),     32'(exp_data));
      check("busy",     32'(busy),     32'(exp_busy));
      check("level",    32'(level),    32'(exp_level));
      check("drop",     32'(drop),     32'(exp_drop));
      check("lines",    32'(lines),    32'(exp_lines));
      check("in_ready", 32'(in_ready), 32'(exp_ready));
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic r);
      applyStimulus(v, d, r);
      checkOutput();
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;

      $display("[TB] reset");
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      repeat (20) step(1'b0, 8'h00, 1'b0);

      $display("[TB] single line");
      for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0);
      repeat (24) step(1'b0, 8'h00, 1'b0);

      $display("[TB] partial line");
      for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0);
      repeat (50) step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'($urandom), 1'b0);
      repeat (25) step(1'b0, 8'h00, 1'b0);

      $display("[TB] back-to-back");
      for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0);
      repeat (40) step(1'b0, 8'h00, 1'b0);

      $display("[TB] overflow");
      for (int i = 0; i < 60; i++) step(1'b1, 8'($urandom), 1'b0);
      repeat (60) step(1'b0, 8'h00, 1'b0);

      $display("[TB] random traffic");
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 99) < 60), 8'($urandom), 1'b0);
      repeat (40) step(1'b0, 8'h00, 1'b0);

      $display("[TB] reset mid-send");
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
      repeat (4) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      repeat (20) step(1'b0, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
